// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/data) single-port memory arbiter
// with timeout abort, sticky halt gating of fetches and per-requester completion pulses.
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [15:0] if_addr_i,
  input  logic        d_req_i,
  input  logic        d_wr_i,
  input  logic [15:0] d_addr_i,
  input  logic [15:0] d_wdata_i,
  input  logic        halt_req_i,
  input  logic [15:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic        mem_en_o,
  output logic        mem_wr_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  output logic [15:0] if_rdata_o,
  output logic [15:0] d_rdata_o,
  output logic        if_done_o,
  output logic        d_done_o,
  output logic        if_stall_o,
  output logic        d_stall_o,
  output logic        err_o,
  output logic        halted_o
);

  localparam int TW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;   // 1 = data owns the bus, 0 = fetch
  logic          wr_q, wr_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   if_rdata_q, if_rdata_d;
  logic [15:0]   d_rdata_q, d_rdata_d;
  logic          if_done_q, if_done_d;
  logic          d_done_q, d_done_d;
  logic          err_q, err_d;
  logic          halt_q, halt_d;
  logic          prio_q, prio_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic fetch_elig;
  logic data_elig;
  logic grant_data;

  // A requester whose done pulse is still visible is excluded so it cannot be reissued.
  assign fetch_elig = if_req_i & ~if_done_q & ~halt_q;
  assign data_elig  = d_req_i & ~d_done_q;
  // prio_q: last grant went to data while fetch was waiting, so fetch goes next.
  assign grant_data = data_elig & ~(prio_q & fetch_elig);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    err_d      = err_q;
    halt_d     = halt_q | halt_req_i;
    prio_d     = prio_q;
    tmo_d      = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (grant_data) begin
          state_d = S_ISSUE;
          owner_d = 1'b1;
          wr_d    = d_wr_i;
          addr_d  = d_addr_i;
          wdata_d = d_wdata_i;
          prio_d  = fetch_elig;
          tmo_d   = '0;
        end else if (fetch_elig) begin
          state_d = S_ISSUE;
          owner_d = 1'b0;
          wr_d    = 1'b0;
          addr_d  = if_addr_i;
          prio_d  = 1'b0;
          tmo_d   = '0;
        end
      end

      S_ISSUE, S_WAIT: begin
        if (mem_ready_i) begin
          state_d = S_IDLE;
          if (owner_q) begin
            d_done_d = 1'b1;
            if (!wr_q) d_rdata_d = mem_rdata_i;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata_i;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          if (owner_q) begin
            d_done_d  = 1'b1;
            d_rdata_d = 16'h0000;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = 16'h0000;
          end
        end else begin
          state_d = S_WAIT;
          tmo_d   = tmo_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      if_rdata_q <= 16'h0000;
      d_rdata_q  <= 16'h0000;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      err_q      <= 1'b0;
      halt_q     <= 1'b0;
      prio_q     <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      err_q      <= err_d;
      halt_q     <= halt_d;
      prio_q     <= prio_d;
      tmo_q      <= tmo_d;
    end
  end

  assign mem_en_o    = (state_q == S_ISSUE);
  assign mem_wr_o    = wr_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign if_done_o   = if_done_q;
  assign d_done_o    = d_done_q;
  assign if_stall_o  = if_req_i & ~if_done_q;
  assign d_stall_o   = d_req_i & ~d_done_q;
  assign err_o       = err_q;
  assign halted_o    = halt_q & (state_q == S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector table plus hand sequences for
// timeout, halt and mid-transaction reset of mem_arbiter.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req, d_req, d_wr, halt_req, mem_ready;
  logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        mem_en, mem_wr, if_done, d_done, if_stall, d_stall, err, halted;
  logic [15:0] mem_addr, mem_wdata, if_rdata, d_rdata;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .d_req_i(d_req), .d_wr_i(d_wr), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .halt_req_i(halt_req), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
    .mem_en_o(mem_en), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .if_rdata_o(if_rdata), .d_rdata_o(d_rdata),
    .if_done_o(if_done), .d_done_o(d_done),
    .if_stall_o(if_stall), .d_stall_o(d_stall),
    .err_o(err), .halted_o(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ifr;
    logic [15:0] ifa;
    logic        dr;
    logic        dw;
    logic [15:0] da;
    logic [15:0] dwd;
    logic        rdy;
    logic [15:0] rd;
    logic        en;
    logic        wr;
    logic [15:0] ma;
    logic [15:0] mwd;
    logic        ifd;
    logic        dd;
    logic [15:0] ifrd;
    logic [15:0] drd;
    logic        ifs;
    logic        ds;
  } vec_t;

  vec_t vecs [15];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
    halt_req = 0; mem_ready = 0; mem_rdata = 0;
  endtask

  initial begin
    //        ifr ifa    dr dw da      dwd    rdy rd       en wr ma      mwd    ifd dd ifrd   drd    ifs ds
    vecs[0]  = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0};
    vecs[1]  = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0};
    vecs[2]  = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0};
    vecs[3]  = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 16'hA5A5, 0, 0, 16'h0010, 16'h0000, 1, 0, 16'hA5A5, 16'h0000, 0, 0};
    vecs[4]  = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0010, 16'h0000, 0, 0, 16'hA5A5, 16'h0000, 0, 0};
    vecs[5]  = '{1, 16'h0040, 1, 0, 16'h0200, 16'h0000, 0, 16'h0000, 1, 0, 16'h0200, 16'h0000, 0, 0, 16'hA5A5, 16'h0000, 1, 1};
    vecs[6]  = '{1, 16'h0040, 1, 0, 16'h0200, 16'h0000, 1, 16'h1111, 0, 0, 16'h0200, 16'h0000, 0, 1, 16'hA5A5, 16'h1111, 1, 0};
    vecs[7]  = '{1, 16'h0040, 1, 0, 16'h0202, 16'h0000, 0, 16'h0000, 1, 0, 16'h0040, 16'h0000, 0, 0, 16'hA5A5, 16'h1111, 1, 1};
    vecs[8]  = '{1, 16'h0040, 1, 0, 16'h0202, 16'h0000, 1, 16'h2222, 0, 0, 16'h0040, 16'h0000, 1, 0, 16'h2222, 16'h1111, 0, 1};
    vecs[9]  = '{0, 16'h0040, 1, 0, 16'h0202, 16'h0000, 0, 16'h0000, 1, 0, 16'h0202, 16'h0000, 0, 0, 16'h2222, 16'h1111, 0, 1};
    vecs[10] = '{0, 16'h0040, 1, 0, 16'h0202, 16'h0000, 1, 16'h3333, 0, 0, 16'h0202, 16'h0000, 0, 1, 16'h2222, 16'h3333, 0, 0};
    vecs[11] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0202, 16'h0000, 0, 0, 16'h2222, 16'h3333, 0, 0};
    vecs[12] = '{0, 16'h0000, 1, 1, 16'h0300, 16'h1234, 0, 16'h0000, 1, 1, 16'h0300, 16'h1234, 0, 0, 16'h2222, 16'h3333, 0, 1};
    vecs[13] = '{0, 16'h0000, 1, 1, 16'h0300, 16'h1234, 1, 16'hBEEF, 0, 1, 16'h0300, 16'h1234, 0, 1, 16'h2222, 16'h3333, 0, 0};
    vecs[14] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 1, 16'h0300, 16'h1234, 0, 0, 16'h2222, 16'h3333, 0, 0};

    rst_n = 0;
    idle_inputs();
    repeat (2) tick();
    chk1("rst mem_en", mem_en, 0);
    chk1("rst mem_wr", mem_wr, 0);
    chk16("rst mem_addr", mem_addr, 16'h0000);
    chk16("rst if_rdata", if_rdata, 16'h0000);
    chk16("rst d_rdata", d_rdata, 16'h0000);
    chk1("rst err", err, 0);
    chk1("rst halted", halted, 0);
    @(negedge clk);
    rst_n = 1;

    // Vector table: fetch-only, simultaneous requests, store.
    for (int i = 0; i < 15; i++) begin
      if_req = vecs[i].ifr; if_addr = vecs[i].ifa;
      d_req = vecs[i].dr; d_wr = vecs[i].dw; d_addr = vecs[i].da; d_wdata = vecs[i].dwd;
      mem_ready = vecs[i].rdy; mem_rdata = vecs[i].rd;
      tick();
      chk1($sformatf("v%0d mem_en", i), mem_en, vecs[i].en);
      chk1($sformatf("v%0d mem_wr", i), mem_wr, vecs[i].wr);
      chk16($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].ma);
      chk16($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].mwd);
      chk1($sformatf("v%0d if_done", i), if_done, vecs[i].ifd);
      chk1($sformatf("v%0d d_done", i), d_done, vecs[i].dd);
      chk16($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].ifrd);
      chk16($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].drd);
      chk1($sformatf("v%0d if_stall", i), if_stall, vecs[i].ifs);
      chk1($sformatf("v%0d d_stall", i), d_stall, vecs[i].ds);
      chk1($sformatf("v%0d err", i), err, 0);
    end

    // Timeout: data load never acknowledged.
    d_req = 1; d_wr = 0; d_addr = 16'h0400; mem_rdata = 16'hFFFF; mem_ready = 0;
    tick();
    chk1("tmo grant mem_en", mem_en, 1);
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk1($sformatf("tmo c%0d err", k), err, 0);
      chk1($sformatf("tmo c%0d d_done", k), d_done, 0);
    end
    tick();
    chk1("tmo err", err, 1);
    chk1("tmo d_done", d_done, 1);
    chk16("tmo d_rdata", d_rdata, 16'h0000);
    d_req = 0;
    if_req = 1; if_addr = 16'h0050;
    tick();
    chk1("post-tmo mem_en", mem_en, 1);
    chk16("post-tmo mem_addr", mem_addr, 16'h0050);
    mem_ready = 1; mem_rdata = 16'h5A5A;
    tick();
    chk1("post-tmo if_done", if_done, 1);
    chk16("post-tmo if_rdata", if_rdata, 16'h5A5A);
    chk1("post-tmo err sticky", err, 1);
    if_req = 0; mem_ready = 0;
    tick();

    // Halt raised while a fetch waits.
    if_req = 1; if_addr = 16'h0060;
    tick();
    chk1("halt issue mem_en", mem_en, 1);
    tick();
    chk1("halt wait mem_en", mem_en, 0);
    halt_req = 1;
    tick();
    chk1("halt inflight halted", halted, 0);
    chk1("halt inflight if_done", if_done, 0);
    halt_req = 0; mem_ready = 1; mem_rdata = 16'h6666;
    tick();
    chk1("halt fetch done", if_done, 1);
    chk16("halt fetch rdata", if_rdata, 16'h6666);
    chk1("halt halted", halted, 1);
    if_req = 0; mem_ready = 0;
    tick();
    if_req = 1; if_addr = 16'h0070;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk1($sformatf("halted fetch c%0d mem_en", k), mem_en, 0);
      chk1($sformatf("halted fetch c%0d if_stall", k), if_stall, 1);
    end
    d_req = 1; d_wr = 0; d_addr = 16'h0700; mem_ready = 1; mem_rdata = 16'h7777;
    tick();
    chk1("halted data mem_en", mem_en, 1);
    chk16("halted data mem_addr", mem_addr, 16'h0700);
    chk1("halted data busy halted", halted, 0);
    tick();
    chk1("halted data d_done", d_done, 1);
    chk16("halted data d_rdata", d_rdata, 16'h7777);
    chk1("halted data back halted", halted, 1);
    d_req = 0; mem_ready = 0;
    tick();
    chk1("halted no fetch mem_en", mem_en, 0);
    if_req = 0;

    // Reset in the middle of a data WAIT.
    d_req = 1; d_wr = 0; d_addr = 16'h0500;
    tick();
    chk1("rstwait issue mem_en", mem_en, 1);
    tick();
    #2;
    rst_n = 0;
    #1;
    chk1("rstwait mem_en", mem_en, 0);
    chk1("rstwait mem_wr", mem_wr, 0);
    chk16("rstwait mem_addr", mem_addr, 16'h0000);
    chk16("rstwait mem_wdata", mem_wdata, 16'h0000);
    chk16("rstwait if_rdata", if_rdata, 16'h0000);
    chk16("rstwait d_rdata", d_rdata, 16'h0000);
    chk1("rstwait err", err, 0);
    chk1("rstwait halted", halted, 0);
    d_req = 0; mem_ready = 1; mem_rdata = 16'h9999;
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1($sformatf("rstwait c%0d d_done", k), d_done, 0);
      chk1($sformatf("rstwait c%0d if_done", k), if_done, 0);
      chk1($sformatf("rstwait c%0d mem_en", k), mem_en, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles from issue to mem_ready before abort.
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-004 if_req  in  1  fetch request, held high until if_done.
REQ-005 if_addr  in  16  fetch address.
REQ-006 d_req  in  1  data request, held high until d_done.
REQ-007 d_wr  in  1  1 = store, 0 = load; qualified by d_req.
REQ-008 d_addr  in  16  data address.
REQ-009 d_wdata  in  16  store data.
REQ-010 halt_req  in  1  processor halt decoded; stops further fetch grants.
REQ-011 mem_rdata  in  16  memory read data, valid with mem_ready.
REQ-012 mem_ready  in  1  memory completion strobe.
REQ-013 mem_en  out  1  one-cycle memory access strobe.
REQ-014 mem_wr  out  1  write qualifier, valid with mem_en.
REQ-015 mem_addr  out  16  registered access address.
REQ-016 mem_wdata  out  16  registered write data.
REQ-017 if_rdata / d_rdata  out  16 each  registered read data per requester.
REQ-018 if_done / d_done  out  1 each  one-cycle completion pulse per requester.
REQ-019 if_stall / d_stall  out  1 each  = req & ~done, combinational.
REQ-020 err  out  1  sticky timeout flag.
REQ-021 halted  out  1  high when halt latched and arbiter IDLE.

Function
REQ-022 FSM states IDLE, ISSUE, WAIT; ISSUE and WAIT tagged by owner (FETCH or DATA).
REQ-023 IDLE -> ISSUE when an eligible request is present; mem_addr/mem_wdata/mem_wr and owner latched on that edge.
REQ-024 Arbitration: data beats fetch, except when the previous grant was DATA and if_req was pending at that grant, fetch wins (anti-starvation).
REQ-025 Fetch eligible only if halt not latched; halt_req latched sticky on first high sample.
REQ-026 ISSUE: mem_en = 1 exactly one cycle; next state WAIT unless mem_ready sampled high in ISSUE.
REQ-027 WAIT: hold, mem_en = 0, mem_addr/mem_wdata/mem_wr stable.
REQ-028 mem_ready high in ISSUE or WAIT -> IDLE; owner's done pulses 1 cycle next cycle; owner's rdata loaded from mem_rdata on reads only; store leaves d_rdata unchanged.
REQ-029 mem_ready sampled in IDLE is ignored.
REQ-030 Requester whose done is high in a cycle is not eligible for grant in that cycle (no duplicate issue).
REQ-031 Minimum transaction: request edge -> ISSUE -> done pulse 2 cycles after request sampled (mem_ready in ISSUE).
REQ-032 Timeout counter (4+ bits) clears on entering ISSUE, increments each ISSUE/WAIT cycle; reaching TIMEOUT without mem_ready -> err = 1, owner's done pulses, owner rdata = 16'h0000, -> IDLE.
REQ-033 err remains 1 until reset; arbitration continues after err.
REQ-034 halted = halt latched & state IDLE; an in-flight fetch completes normally before halted rises; data requests still serviced while halted.

Reset
REQ-035 rst_n low asynchronously forces IDLE and clears mem_en, mem_wr, mem_addr, mem_wdata, if_rdata, d_rdata, if_done, d_done, err, halted, halt latch, timeout counter, last-grant flag to 0.
REQ-036 Reset during ISSUE/WAIT discards the transaction; no done pulse after rst_n rises.
REQ-037 First grant possible on the first rising edge with rst_n high.

Verification
REQ-038 Fetch only: if_addr=16'h0010, mem_ready 3 cycles after mem_en, mem_rdata=16'hA5A5 -> one mem_en pulse, mem_addr=0010, if_done 1 cycle, if_rdata=A5A5, if_stall low after.
REQ-039 Simultaneous if_req and d_req (load 16'h0200) -> DATA granted first, FETCH granted next even if d_req reasserted immediately.
REQ-040 Store d_addr=16'h0300 d_wdata=16'h1234 -> mem_en & mem_wr one cycle, mem_wdata=1234, d_rdata unchanged, d_done pulse.
REQ-041 mem_ready never asserted -> after 15 ISSUE/WAIT cycles err=1, d_done/if_done pulse, rdata=0000, next request still serviced.
REQ-042 halt_req during fetch WAIT -> fetch completes, halted=1, later if_req gets no mem_en; rst_n low mid-WAIT -> all outputs 0, no done pulse.
